// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter.
// Lock mode enum, burst counter width and index-width helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    localparam int BURST_CNT_W = 8;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_push_arb_if.sv
// Producer/FIFO write-side bundle around the push arbiter.
// master: the arbiter; slave: producers plus FIFO full.
interface fifo_push_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*DATA_W-1:0] din;
    logic [NUM_REQ-1:0]        gnt;
    logic                      full;
    logic                      push;
    logic [DATA_W-1:0]         wdata;

    modport master (
        input  req, lock, din, full,
        output gnt, push, wdata
    );

    modport slave (
        output req, lock, din, full,
        input  gnt, push, wdata
    );
endinterface

// File: rtl/fifo_push_arb_rr_pick.sv
// Combinational round-robin one-hot picker.
// First set mask bit at or after ptr, wrapping at N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && mask[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
                onehot[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing the async FIFO push port.
// Burst lock is built only with FIFO_PUSH_ARB_LOCK_EN.
module fifo_push_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input logic             wclk,
    input logic             reset,
    fifo_push_arb_if.master bus
);
    localparam int IW = idx_w(NUM_REQ);

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      ptr_nxt;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      win_inc;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_any;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .mask   (mask),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    assign win_inc = (int'(win_idx) == NUM_REQ - 1)
                   ? '0 : win_idx + 1'b1;

    assign bus.gnt   = win_oh;
    assign bus.push  = win_any;
    assign bus.wdata = win_any
                     ? bus.din[int'(win_idx)*DATA_W +: DATA_W]
                     : '0;

`ifdef FIFO_PUSH_ARB_LOCK_EN
    localparam logic [BURST_CNT_W-1:0] MAX_CNT =
        BURST_CNT_W'(MAX_BURST);

    arb_state_t             fsm;
    arb_state_t             fsm_nxt;
    logic [IW-1:0]          owner;
    logic [IW-1:0]          owner_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [BURST_CNT_W-1:0] cnt_nxt;
    logic [BURST_CNT_W-1:0] cnt_inc;
    logic [NUM_REQ-1:0]     own_oh;
    logic                   own_req;
    logic                   own_lock;

    assign own_oh   = NUM_REQ'(1) << owner;
    assign own_req  = |(bus.req & own_oh);
    assign own_lock = |(bus.lock & own_oh);
    assign cnt_inc  = burst_cnt + 1'b1;

    // While locked, everyone but the owner is held off.
    always_comb begin
        mask = bus.req;
        if (fsm == LOCKED)
            mask = bus.req & own_oh;
        if (reset || bus.full)
            mask = '0;
    end

    always_comb begin
        fsm_nxt   = fsm;
        owner_nxt = owner;
        cnt_nxt   = burst_cnt;
        ptr_nxt   = ptr;
        unique case (fsm)
            IDLE: begin
                if (win_any) begin
                    ptr_nxt = win_inc;
                    if (|(bus.lock & win_oh) && MAX_BURST > 1) begin
                        fsm_nxt   = LOCKED;
                        owner_nxt = win_idx;
                        cnt_nxt   = BURST_CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // A full FIFO freezes the burst; the lock persists.
                if (!bus.full) begin
                    if (win_any)
                        cnt_nxt = cnt_inc;
                    if (!own_req || !own_lock ||
                        (win_any && cnt_inc == MAX_CNT)) begin
                        fsm_nxt = IDLE;
                        cnt_nxt = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            fsm       <= IDLE;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            ptr       <= ptr_nxt;
            fsm       <= fsm_nxt;
            owner     <= owner_nxt;
            burst_cnt <= cnt_nxt;
        end
    end
`else
    localparam int unused_max_burst = MAX_BURST;

    logic unused_lock;
    assign unused_lock = ^bus.lock;

    assign mask    = (reset || bus.full) ? '0 : bus.req;
    assign ptr_nxt = win_any ? win_inc : ptr;

    always_ff @(posedge wclk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end
`endif
endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin arbiter that shares the write (push) port of the asynchronous 2-entry FIFO among `NUM_REQ` requesters in the `wclk` domain. Each cycle it grants at most one requester whose `full` is low and forwards that requester's data to the FIFO with `push`. An optional lock mode lets a requester hold the port for a bounded burst. The block sits between the producers and the FIFO write-side `dut` modport.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 8: FIFO data width.
- `MAX_BURST`, 4: maximum consecutive pushes granted to one locked owner, 1..255.
- `wclk`  input  1  write-domain clock.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  NUM_REQ  per-requester push request; the requester holds it and its data until granted.
- `lock`  input  NUM_REQ  per-requester burst-lock request; only meaningful together with `req`.
- `din`  input  NUM_REQ*DATA_W  per-requester data; slice i is `din[i*DATA_W +: DATA_W]`.
- `gnt`  output  NUM_REQ  one-hot grant; `gnt[i]`=1 means requester i's word is pushed at this edge.
- `full`  input  1  FIFO full, synchronous to `wclk`.
- `push`  output  1  FIFO push, equal to `|gnt`.
- `wdata`  output  DATA_W  data of the granted requester; all zeros when `push`=0.

## Operation
- State: `ptr`, the round-robin start index (log2 NUM_REQ bits); `fsm` in {IDLE, LOCKED}; `owner`, the locked index; `burst_cnt`, 8 bits.
- Eligibility: no grant is issued when `full`=1 or `reset`=1.
- IDLE: the winner is the first set `req` bit searching from `ptr` upward with wrap. `gnt` is one-hot on the winner. At the edge, `ptr` becomes winner+1 mod NUM_REQ.
  - If the winner also has `lock` set (lock build only), go to LOCKED with `owner`=winner and `burst_cnt`=1.
- LOCKED: only `owner` is eligible, and other requests are held off.
  - A push by the owner increments `burst_cnt`.
  - Release to IDLE at the edge where any of these holds: `req[owner]`=0, `lock[owner]`=0, or a push brings `burst_cnt` to MAX_BURST.
  - `ptr` stays at owner+1 for the whole burst.
- In LOCKED with `full`=1, no push occurs and the state is held; the lock persists.
- If `req[i]` drops while not granted, that is legal: the request is withdrawn with no side effect.
- With MAX_BURST=1, LOCKED is never entered and lock is a no-op.

## Timing
- Zero latency: `gnt`, `push` and `wdata` are combinational from `req`, `lock`, `full` and registered state, within the same cycle.
- One push per cycle at most. Back-to-back grants to different requesters in consecutive cycles are allowed.
- While `reset`=1: `ptr`=0, `fsm`=IDLE, `owner`=0, `burst_cnt`=0; `gnt`=0, `push`=0, `wdata`=0.
- Reset asserted mid-burst: the lock is dropped immediately and the next grant after deassertion starts from index 0.
- `full` rising in the same cycle as `req`: no grant, and `ptr` is unchanged.
- No edge is missed at `ptr` wrap, e.g. NUM_REQ-1 to 0.

## Configuration
- `FIFO_PUSH_ARB_LOCK_EN` defined: the lock behaviour above, with the LOCKED state and `burst_cnt`.
- Undefined: the `lock` port is present but ignored, `fsm` is fixed at IDLE and `burst_cnt` is removed, giving a pure per-push round-robin.

## Structure
- Package `fifo_arb_pkg` holds:
  - the `arb_state_t` enum {IDLE, LOCKED};
  - the `BURST_CNT_W`=8 constant;
  - a `clog2`-based index-width helper.
- Sub-module `rr_pick`: a combinational one-hot picker, taking the mask and start pointer and returning the one-hot winner and its index. It is reused by any future read-side scheduler.

## Test plan
- NUM_REQ=4, `req`=4'b1111, `full`=0, reset released: grants go to 0,1,2,3,0 on consecutive cycles, and `wdata` matches each `din` slice.
- `req`=4'b1010, `ptr`=0: `gnt`=4'b0010 and then 4'b1000, with `ptr` ending at 0 after wrap.
- `full`=1 for 3 cycles with `req`=4'b0100: `gnt`=0 and `push`=0 throughout. On the cycle `full`=0, `gnt`=4'b0100.
- Lock build, MAX_BURST=4, req/lock[1] held, `req[2]` also held: four consecutive grants to 1, then release, then 2 is granted next.
- Lock build, with `full` pulsed mid-burst after the 2nd push: the burst resumes to exactly 4 pushes and requester 2 is not granted while `full`=1.
- `reset` asserted during LOCKED: `gnt`/`push` go to 0 immediately. After release, with `req`=4'b1111, the first grant is index 0.
